// File: rtl/adjust_seq.sv
// adjust_seq: front-panel adjust-mode sequencer.
// Walks NFIELD time fields, strobes INC/CLR, blinks the selected field.
module adjust_seq #(
  parameter int NFIELD  = 2,
  parameter int REP_DLY = 4,
  parameter int REP_PER = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SIG2HZ,
  input  logic                         TICK,
  input  logic                         MODE1,
  input  logic                         SELECT1,
  input  logic                         SELHOLD,
  input  logic                         ADJUST1,
  output logic [NFIELD-1:0]            CLR,
  output logic [NFIELD-1:0]            INC,
  output logic [NFIELD-1:0]            ON,
  output logic                         ADJ,
  output logic [$clog2(NFIELD+1)-1:0]  FIELD
);

  localparam int SW = $clog2(NFIELD+1);
  localparam int RW = $clog2(REP_DLY+REP_PER+1);
  localparam int TW = $clog2(TIMEOUT+2);

  localparam logic [SW-1:0] ST_NORM = '0;
  localparam logic [SW-1:0] ST_MAX  = SW'(NFIELD);

  localparam logic [RW-1:0] R_FIRST = RW'(REP_DLY-1);
  localparam logic [RW-1:0] R_LAST  = RW'(REP_DLY+REP_PER-1);
  localparam logic [RW-1:0] R_LOOP  = RW'(REP_DLY);

  localparam logic [TW-1:0] T_LAST  =
    TW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

  logic [SW-1:0] st_q, st_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic in_adj;
  logic act;
  logic rep;
  logic t_exp;

  // a valid field is selected; out-of-range codes count as idle
  assign in_adj = (st_q != ST_NORM) && (st_q <= ST_MAX);

  // any key activity holds off the inactivity timeout
  assign act = MODE1 | SELECT1 | ADJUST1 | SELHOLD;

  // auto-repeat: first fire after REP_DLY ticks, then every REP_PER
  always_comb begin
    rep    = 1'b0;
    rcnt_d = rcnt_q;
    if (!SELHOLD || !in_adj || MODE1) begin
      rcnt_d = '0;
    end else if (TICK) begin
      if (rcnt_q == R_FIRST) begin
        rep    = 1'b1;
        rcnt_d = rcnt_q + RW'(1);
      end else if (rcnt_q == R_LAST) begin
        rep    = 1'b1;
        rcnt_d = R_LOOP;
      end else if (rcnt_q < R_LAST) begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  // inactivity timer; TIMEOUT of zero never expires
  always_comb begin
    t_exp  = 1'b0;
    tcnt_d = tcnt_q;
    if (act || !in_adj) begin
      tcnt_d = '0;
    end else if (TICK && (TIMEOUT != 0)) begin
      if (tcnt_q == T_LAST) begin
        t_exp  = 1'b1;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // field stepping; MODE1 outranks expiry since it is activity
  always_comb begin
    st_d = st_q;
    if (!in_adj) begin
      if ((st_q == ST_NORM) && MODE1)
        st_d = SW'(1);
      else
        st_d = ST_NORM;
    end else if (MODE1) begin
      if (st_q == ST_MAX)
        st_d = ST_NORM;
      else
        st_d = st_q + SW'(1);
    end else if (t_exp) begin
      st_d = ST_NORM;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= ST_NORM;
      rcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      rcnt_q <= rcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  // strobes and blanking only for the selected field
  always_comb begin
    CLR = '0;
    INC = '0;
    ON  = '1;
    for (int i = 0; i < NFIELD; i++) begin
      if (st_q == SW'(i+1)) begin
        CLR[i] = ADJUST1 & ~MODE1;
        INC[i] = (SELECT1 | rep) & ~ADJUST1 & ~MODE1;
        ON[i]  = ~SIG2HZ;
      end
    end
  end

  assign ADJ   = (st_q != ST_NORM);
  assign FIELD = st_q;

endmodule

// File: tb/tb_adjust_seq.sv
// tb_adjust_seq: directed checks of adjust_seq with NFIELD=3,
// REP_DLY=4, REP_PER=2, TIMEOUT=8.
module tb_adjust_seq;

  logic       clk;
  logic       rst;
  logic       sig2hz;
  logic       tick;
  logic       mode1;
  logic       select1;
  logic       selhold;
  logic       adjust1;
  logic [2:0] clr;
  logic [2:0] inc;
  logic [2:0] on;
  logic       adj;
  logic [1:0] field;

  int tests;
  int fails;

  adjust_seq #(
    .NFIELD (3),
    .REP_DLY(4),
    .REP_PER(2),
    .TIMEOUT(8)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .SIG2HZ (sig2hz),
    .TICK   (tick),
    .MODE1  (mode1),
    .SELECT1(select1),
    .SELHOLD(selhold),
    .ADJUST1(adjust1),
    .CLR    (clr),
    .INC    (inc),
    .ON     (on),
    .ADJ    (adj),
    .FIELD  (field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // one cycle of inputs, applied at the falling edge
  task automatic cyc(input logic m, input logic s,
                     input logic h, input logic a,
                     input logic t);
    @(negedge clk);
    mode1   = m;
    select1 = s;
    selhold = h;
    adjust1 = a;
    tick    = t;
    #1;
  endtask

  task automatic goto(input int k);
    for (int i = 0; i < 8 && int'(field) != k; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("goto", int'(field), k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    sig2hz  = 1'b0;
    tick    = 1'b0;
    mode1   = 1'b0;
    select1 = 1'b0;
    selhold = 1'b0;
    adjust1 = 1'b0;

    // reset state
    cyc(0, 0, 0, 0, 0);
    chk("rst_field", int'(field), 0);
    chk("rst_on", int'(on), 7);
    chk("rst_adj", int'(adj), 0);
    chk("rst_inc", int'(inc), 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_field", int'(field), 0);

    // MODE1 walks 1,2,3,0 with no strobe in the press cycle
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0, 0, 0);
      chk("mode_no_inc", int'(inc), 0);
      cyc(0, 0, 0, 0, 0);
      chk("mode_field", int'(field), k % 4);
      chk("mode_adj", int'(adj), (k % 4) != 0 ? 1 : 0);
    end

    // strobes and blink on field 2
    goto(2);
    sig2hz = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("sel_inc", int'(inc), 2);
    chk("sel_on", int'(on), 5);
    chk("sel_clr", int'(clr), 0);
    cyc(0, 0, 0, 0, 0);
    chk("sel_one_wide", int'(inc), 0);
    cyc(0, 1, 0, 1, 0);
    chk("clr_beats_inc_clr", int'(clr), 2);
    chk("clr_beats_inc_inc", int'(inc), 0);
    sig2hz = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("unblank_on", int'(on), 7);

    // MODE1 suppresses SELECT1
    goto(1);
    cyc(1, 1, 0, 0, 0);
    chk("mode_sel_inc", int'(inc), 0);
    cyc(0, 0, 0, 0, 0);
    chk("mode_sel_field", int'(field), 2);

    // auto-repeat on field 1
    goto(1);
    for (int n = 1; n <= 10; n++) begin
      cyc(0, 0, 1, 0, 1);
      chk($sformatf("rep_tick%0d", n), int'(inc),
          (n >= 4 && n % 2 == 0) ? 1 : 0);
      cyc(0, 0, 1, 0, 0);
      chk("rep_notick", int'(inc), 0);
    end
    cyc(0, 0, 0, 0, 0);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 1, 0, 1);
      chk($sformatf("rehold_tick%0d", n), int'(inc),
          n == 4 ? 1 : 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);

    // timeout after 8 idle ticks
    goto(3);
    for (int n = 1; n <= 8; n++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("to_tick%0d", n), int'(field),
          n == 8 ? 0 : 3);
    end

    // SELECT1 on tick 5 restarts the count
    goto(3);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      if (n >= 7)
        chk($sformatf("to_post_sel%0d", n), int'(field),
            n == 8 ? 0 : 3);
    end

    // MODE1 on the expiring tick advances instead
    goto(2);
    for (int n = 1; n <= 7; n++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("mode_beats_to", int'(field), 3);

    // async reset while a repeat strobe is active
    goto(1);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 1, 0, 1);
      if (n < 4) cyc(0, 0, 1, 0, 0);
    end
    chk("pre_rst_inc", int'(inc), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_inc", int'(inc), 0);
    chk("async_field", int'(field), 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    goto(1);
    for (int n = 1; n <= 4; n++) begin
      cyc(0, 0, 1, 0, 1);
      chk($sformatf("rst_rep%0d", n), int'(inc),
          n == 4 ? 1 : 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adjust_seq.md
# adjust_seq

Parametrised adjust-mode sequencer for the clock front panel: it steps through NFIELD adjustable time fields (min, hour, day, …), issues per-field increment and clear strobes to the counter chain, and blanks the selected field at the blink rate. Over a fixed three-state adjust FSM it adds an arbitrary field count, auto-repeat while SELECT is held, and an inactivity timeout back to normal display. It sits between the debounced key one-shots and the time-counter block.

## Interface
- NFIELD, 2: number of adjustable fields (1..15); field 0 is the lowest-order field.
- REP_DLY, 4: TICKs of continuous SELHOLD before the first auto-repeat (>=1).
- REP_PER, 2: TICKs between subsequent auto-repeats (>=1).
- TIMEOUT, 16: TICKs without key activity before returning to normal; 0 disables the timeout.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- SIG2HZ  in  1  blink level (1 = blank phase).
- TICK  in  1  single-cycle timebase strobe for repeat and timeout counting.
- MODE1  in  1  one-cycle pulse: advance to next field.
- SELECT1  in  1  one-cycle pulse: increment selected field.
- SELHOLD  in  1  level: select key currently held.
- ADJUST1  in  1  one-cycle pulse: clear selected field.
- CLR  out  NFIELD  per-field clear strobe.
- INC  out  NFIELD  per-field increment strobe.
- ON  out  NFIELD  per-field display enable (0 = blanked).
- ADJ  out  1  1 when not in normal display.
- FIELD  out  SW=$clog2(NFIELD+1)  current state index.

## Operation
- State register st, width SW: 0 = NORM, k = adjusting field k-1 (k = 1..NFIELD).
- Transitions: MODE1 in NORM -> 1; MODE1 in k<NFIELD -> k+1; MODE1 in NFIELD -> 0; timeout expiry in any k -> 0; otherwise hold. Out-of-range codes -> 0 on the next edge.
- Outputs are combinational from registered state and current inputs, for selected field i = st-1 only:
  - CLR[i] = ADJUST1 & ~MODE1.
  - INC[i] = (SELECT1 | rep) & ~ADJUST1 & ~MODE1 (clear beats increment; MODE1 suppresses both).
  - ON[i] = ~SIG2HZ; all other ON bits = 1. ADJ = (st != 0). FIELD = st.
  - In NORM all CLR/INC = 0 and all ON = 1.
- Auto-repeat counter rcnt (saturating width for REP_DLY+REP_PER): cleared when SELHOLD=0, st=0, or MODE1=1. On a TICK cycle with SELHOLD=1 and st!=0:
  - rcnt == REP_DLY-1: rep=1, rcnt <- rcnt+1.
  - rcnt == REP_DLY+REP_PER-1: rep=1, rcnt <- REP_DLY.
  - otherwise rep=0, rcnt <- rcnt+1.
  - rep is 0 on all non-TICK cycles; rep needs no SELECT1, it is the TICK cycle itself.
- Timeout counter tcnt: cleared on any of MODE1, SELECT1, ADJUST1, SELHOLD, or st=0. On TICK with no activity in st!=0: tcnt == TIMEOUT-1 -> st <- 0, tcnt <- 0; else tcnt+1. With TIMEOUT=0 it never expires.
- Simultaneous: MODE1 with timeout -> MODE1 transition wins (activity clears tcnt). SELECT1 with rep in the same cycle -> single INC cycle.

## Timing
- Reset (async, immediate): st=0, rcnt=0, tcnt=0. Hence CLR=0, INC=0, ON=all 1, ADJ=0, FIELD=0 while RST=1 and after release until a key is pressed.
- MODE1 at cycle n -> FIELD/ADJ/ON change at cycle n+1; no strobe in cycle n.
- SELECT1/ADJUST1 at cycle n -> INC/CLR asserted in cycle n only, zero latency, one cycle wide.
- Auto-repeat: first rep on the REP_DLY-th TICK of hold, then every REP_PER TICKs; release clears rcnt by the next edge.
- Timeout: st returns to 0 on the edge after the TIMEOUT-th idle TICK.
- RST mid-adjust or mid-hold aborts; strobes drop asynchronously.

## Test plan
- Reset and cycle: NFIELD=3; RST pulse -> FIELD=0, ON=3'b111, ADJ=0; four MODE1 pulses -> FIELD 1,2,3,0 on successive following cycles.
- Strobes and blink: FIELD=2, SIG2HZ=1, SELECT1 pulse -> INC=3'b010 for one cycle, ON=3'b101; ADJUST1+SELECT1 together -> CLR=3'b010, INC=0.
- Auto-repeat: REP_DLY=4, REP_PER=2, FIELD=1, SELHOLD held 10 TICKs -> INC[0] on TICKs 4, 6, 8, 10; release then re-hold -> next pulse on the 4th TICK again.
- Timeout: TIMEOUT=8, FIELD=3, no keys -> FIELD=0 after the 8th TICK; a SELECT1 at TICK 5 postpones expiry to 8 TICKs after it.
- Priority: MODE1 with SELECT1 in FIELD=1 -> INC=0, FIELD=2 next cycle; MODE1 on the expiring TICK -> FIELD advances, not 0.
- Async reset mid-hold: RST asserted between edges while INC active -> INC=0, FIELD=0 immediately; repeat restarts from zero.
